matrix_mac_engine: RTL and testbench
====================================

MATRIX_MAC_ENGINE -- requirements
Module: matrix_mac_engine

Interface
REQ-001 Parameter N, default 4: matrix dimension (N x N operands and result); N >= 2.
REQ-002 Parameter DW, default 8: unsigned operand element width.
REQ-003 Parameter AW, default 32: accumulator element width; AW >= 2*DW.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  request one multiply-accumulate pass; accepted only when ready=1.
REQ-007 clear  input  1  zero accumulators (rules in Function).
REQ-008 matrix_a  input  N*N*DW  operand A; element (i,j) at bits [(i*N+j)*DW +: DW].
REQ-009 matrix_b  input  N*N*DW  operand B; same packing.
REQ-010 ready  output  1  engine idle, start will be accepted.
REQ-011 busy  output  1  pass in progress.
REQ-012 done  output  1  one-cycle pulse: pass complete, res final.
REQ-013 res  output  N*N*AW  accumulator matrix; element (i,j) at bits [(i*N+j)*AW +: AW].
REQ-014 ovf  output  1  sticky accumulation-overflow flag.

Function
REQ-015 FSM states IDLE, COMPUTE, DONE; IDLE->COMPUTE on start; COMPUTE->DONE after N cycles; DONE->IDLE unconditionally after one cycle.
REQ-016 ready=1 only in IDLE; busy=1 in COMPUTE and DONE; done=1 only in DONE.
REQ-017 On start acceptance, matrix_a and matrix_b are latched internally; input changes afterwards have no effect on the pass.
REQ-018 COMPUTE uses a k counter 0..N-1; each cycle all N*N cells perform acc(i,j) += A(i,k)*B(k,j).
REQ-019 Latency: start accepted at edge T -> done=1 during cycle T+N+1 (N COMPUTE cycles, then DONE).
REQ-020 Products are unsigned 2*DW bits, zero-extended to AW before addition.
REQ-021 clear together with an accepted start: accumulators start the pass from zero (result = A*B only).
REQ-022 clear in IDLE without start: all accumulators and ovf become 0 at the next edge.
REQ-023 clear and start are ignored while busy=1; start in DONE is not accepted.
REQ-024 Without clear, a new pass adds onto existing accumulator contents (running MAC across passes).
REQ-025 res is driven directly from the accumulators; values are final only while done=1 or in IDLE.
REQ-026 ovf sets when any cell's addition carries out of AW bits; it stays set until clear or rst.

Reset
REQ-027 rst=1 immediately forces IDLE, k=0, accumulators=0, latched operands=0, ovf=0, done=0, busy=0, ready=1, regardless of state, including mid-COMPUTE.
REQ-028 First start is accepted on the first rising edge after rst deasserts.

Configuration
REQ-029 With MMAC_SATURATE_EN defined, an overflowing accumulation clamps the cell to 2^AW-1 and holds there; ovf behaves per REQ-026.
REQ-030 Without MMAC_SATURATE_EN, accumulation wraps modulo 2^AW.

Structure
REQ-031 Package mmac_pkg holds the FSM state enum typedef, default values of N/DW/AW and the element-index packing function.
REQ-032 Sub-module mmac_pe is one MAC cell (accumulator register, product, add, overflow/saturation); the top instantiates N*N of them through generate loops.

Verification (N=4, DW=8, AW=32 unless stated)
REQ-033 A=identity, B(i,j)=4i+j, clear+start -> done 5 cycles after acceptance; res(i,j)=4i+j; ovf=0.
REQ-034 Repeat REQ-033 start without clear -> res(i,j)=2*(4i+j); a third pass with clear -> back to 4i+j.
REQ-035 All A and B elements 255, clear+start -> every res element 260100; ovf=0.
REQ-036 AW=16, all elements 255, clear+start -> 63492 per element, ovf=1 without the macro; 65535 per element, ovf=1 with MMAC_SATURATE_EN.
REQ-037 rst pulsed in the 2nd COMPUTE cycle -> res=0, busy=0, done=0 and ready=1 immediately; start and clear applied while busy change nothing.
REQ-038 After any pass, clear in IDLE -> res all 0 and ovf=0 one cycle later; no done pulse.

Source files
------------

// File: rtl/mmac_pkg.sv
// Shared types, defaults and the element packing helper for the matrix MAC engine.
package mmac_pkg;

  localparam int unsigned DefN  = 4;
  localparam int unsigned DefDw = 8;
  localparam int unsigned DefAw = 32;

  typedef enum logic [1:0] {
    StIdle,
    StCompute,
    StDone
  } mmac_state_e;

  // Flat index of element (i,j) in an n x n row-major packed matrix.
  function automatic int unsigned elem_idx(input int unsigned i, input int unsigned j,
                                           input int unsigned n);
    return i * n + j;
  endfunction

endpackage

// File: rtl/matrix_mac_engine_if.sv
// Command/result bundle of the matrix MAC engine; the engine is the slave side.
import mmac_pkg::*;

interface matrix_mac_engine_if #(
  parameter int unsigned N  = DefN,
  parameter int unsigned DW = DefDw,
  parameter int unsigned AW = DefAw
);

  logic                  start;
  logic                  clear;
  logic [N*N*DW-1:0]     matrix_a;
  logic [N*N*DW-1:0]     matrix_b;
  logic                  ready;
  logic                  busy;
  logic                  done;
  logic [N*N*AW-1:0]     res;
  logic                  ovf;

  modport master (
    output start, clear, matrix_a, matrix_b,
    input  ready, busy, done, res, ovf
  );

  modport slave (
    input  start, clear, matrix_a, matrix_b,
    output ready, busy, done, res, ovf
  );

endinterface

// File: rtl/mmac_pe.sv
// One multiply-accumulate cell. Wraps on overflow by default; clamps to all-ones when
// MMAC_SATURATE_EN is defined.
import mmac_pkg::*;

module mmac_pe #(
  parameter int unsigned DW = DefDw,
  parameter int unsigned AW = DefAw
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [AW-1:0] acc,
  output logic          carry
);

  logic [2*DW-1:0] prod;
  logic [AW:0]     sum;
  logic [AW-1:0]   acc_q, acc_d;

  always_comb begin
    prod  = (2*DW)'(a) * (2*DW)'(b);
    sum   = {1'b0, acc_q} + {{(AW + 1 - 2*DW){1'b0}}, prod};
    carry = en & sum[AW];
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
`ifdef MMAC_SATURATE_EN
      acc_d = sum[AW] ? '1 : sum[AW-1:0];
`else
      acc_d = sum[AW-1:0];
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/matrix_mac_engine.sv
// N x N matrix multiply-accumulate engine: one k step per COMPUTE cycle across all cells.
// Optional saturation of accumulators with MMAC_SATURATE_EN (see mmac_pe).
import mmac_pkg::*;

module matrix_mac_engine #(
  parameter int unsigned N  = DefN,
  parameter int unsigned DW = DefDw,
  parameter int unsigned AW = DefAw
) (
  input logic                clk,
  input logic                rst,
  matrix_mac_engine_if.slave bus
);

  localparam int unsigned KW = $clog2(N);
  localparam logic [KW-1:0] KLast = KW'(N - 1);

  mmac_state_e       state_q, state_d;
  logic [KW-1:0]     k_q;
  logic [N*N*DW-1:0] a_q, b_q;
  logic              ovf_q;
  logic              accept, clr_acc, compute_en;
  logic [N*N-1:0]    carry;

  assign accept     = (state_q == StIdle) & bus.start;
  assign clr_acc    = (state_q == StIdle) & bus.clear;
  assign compute_en = (state_q == StCompute);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (bus.start) state_d = StCompute;
      StCompute: if (k_q == KLast) state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q <= bus.matrix_a;
        b_q <= bus.matrix_b;
        k_q <= '0;
      end else if (compute_en) begin
        k_q <= (k_q == KLast) ? '0 : k_q + 1'b1;
      end
      if (clr_acc) begin
        ovf_q <= 1'b0;
      end else if (|carry) begin
        ovf_q <= 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      logic [DW-1:0] a_el, b_el;
      // Cell (i,j) consumes A(i,k) and B(k,j) for the current k.
      assign a_el = a_q[elem_idx(gi, 32'(k_q), N)*DW +: DW];
      assign b_el = b_q[elem_idx(32'(k_q), gj, N)*DW +: DW];

      mmac_pe #(
        .DW(DW),
        .AW(AW)
      ) u_pe (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr_acc),
        .en   (compute_en),
        .a    (a_el),
        .b    (b_el),
        .acc  (bus.res[(gi*N+gj)*AW +: AW]),
        .carry(carry[gi*N+gj])
      );
    end
  end

  assign bus.ready = (state_q == StIdle);
  assign bus.busy  = (state_q == StCompute) | (state_q == StDone);
  assign bus.done  = (state_q == StDone);
  assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_matrix_mac_engine.sv
// Randomised self-checking bench: a 32-bit and a 16-bit accumulator engine vs a matrix model.
import mmac_pkg::*;

module tb_matrix_mac_engine;

  localparam int unsigned N   = 4;
  localparam int unsigned DW  = 8;
  localparam int unsigned AW0 = 32;
  localparam int unsigned AW1 = 16;
`ifdef MMAC_SATURATE_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  matrix_mac_engine_if #(.N(N), .DW(DW), .AW(AW0)) bus0 ();
  matrix_mac_engine_if #(.N(N), .DW(DW), .AW(AW1)) bus1 ();

  matrix_mac_engine #(.N(N), .DW(DW), .AW(AW0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  matrix_mac_engine #(.N(N), .DW(DW), .AW(AW1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int vectors = 0;
  int miscompares = 0;

  int unsigned op_a[N][N];
  int unsigned op_b[N][N];
  longint      m_acc[2][N][N];
  bit          m_ovf[2];

  function automatic logic [N*N*DW-1:0] pack(input bit use_b);
    logic [N*N*DW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        v[(i*N+j)*DW +: DW] = use_b ? DW'(op_b[i][j]) : DW'(op_a[i][j]);
    return v;
  endfunction

  function automatic logic [N*N*DW-1:0] rand_vec();
    logic [N*N*DW-1:0] v;
    for (int i = 0; i < N*N; i++) v[i*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  function automatic longint get_res(input int d, input int i, input int j);
    if (d == 0) return longint'(bus0.res[(i*N+j)*AW0 +: AW0]);
    return longint'(bus1.res[(i*N+j)*AW1 +: AW1]);
  endfunction

  function automatic bit get_ovf(input int d);   return d == 0 ? bus0.ovf   : bus1.ovf;   endfunction
  function automatic bit get_done(input int d);  return d == 0 ? bus0.done  : bus1.done;  endfunction
  function automatic bit get_busy(input int d);  return d == 0 ? bus0.busy  : bus1.busy;  endfunction
  function automatic bit get_ready(input int d); return d == 0 ? bus0.ready : bus1.ready; endfunction

  task automatic drive(input int d, input bit s, input bit c,
                       input logic [N*N*DW-1:0] pa, input logic [N*N*DW-1:0] pb);
    if (d == 0) begin
      bus0.start = s; bus0.clear = c; bus0.matrix_a = pa; bus0.matrix_b = pb;
    end else begin
      bus1.start = s; bus1.clear = c; bus1.matrix_a = pa; bus1.matrix_b = pb;
    end
  endtask

  // Reference: res = (clr ? 0 : res) + A*B, element by element with wrap or clamp.
  task automatic model_pass(input int d, input bit clr);
    longint lim;
    lim = longint'(1) << (d == 0 ? AW0 : AW1);
    if (clr) m_ovf[d] = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        if (clr) m_acc[d][i][j] = 0;
        for (int k = 0; k < N; k++) begin
          longint s;
          s = m_acc[d][i][j] + longint'(op_a[i][k]) * longint'(op_b[k][j]);
          if (s >= lim) begin
            m_ovf[d] = 1'b1;
            s = Sat ? lim - 1 : s - lim;
          end
          m_acc[d][i][j] = s;
        end
      end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_ovf[d] = 1'b0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) m_acc[d][i][j] = 0;
    end
  endtask

  // Starts a pass, then scrambles operands and holds start/clear high while busy.
  // Returns edges from acceptance until done is seen (-1 on timeout); ends in DONE.
  task automatic run_pass(input int d, input bit clr, output int lat);
    drive(d, 1'b1, clr, pack(1'b0), pack(1'b1));
    @(posedge clk); #1;
    model_pass(d, clr);
    drive(d, 1'b1, 1'b1, rand_vec(), rand_vec());
    lat = 0;
    while (get_done(d) !== 1'b1 && lat < 4 * N) begin
      @(posedge clk); #1;
      lat++;
    end
    if (get_done(d) !== 1'b1) lat = -1;
    drive(d, 1'b0, 1'b0, rand_vec(), rand_vec());
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (get_ready(d) !== 1'b1 || get_busy(d) !== 1'b0 || get_done(d) !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_ctrl dut%0d: ready/busy/done=%b%b%b, want 100", d,
                 get_ready(d), get_busy(d), get_done(d));
      end
      vectors++;
      if (get_ovf(d) !== 1'b0 || (d == 0 ? bus0.res !== '0 : bus1.res !== '0)) begin
        miscompares++;
        $display("FAIL reset_res dut%0d: ovf=%b res(0,0)=%0d, want 0/0", d, get_ovf(d),
                 get_res(d, 0, 0));
      end
    end
  endtask

  task automatic test_identity();
    int lat;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          op_a[i][j] = (i == j) ? 1 : 0;
          op_b[i][j] = 4 * i + j;
        end
      // Pass 0 clears, pass 1 accumulates onto it, pass 2 clears again.
      run_pass(0, p != 1, lat);
      vectors++;
      if (lat != N) begin
        miscompares++;
        $display("FAIL identity_latency pass%0d: got %0d edges, want %0d", p, lat, N);
      end
      vectors++;
      if (bus0.busy !== 1'b1 || bus0.ready !== 1'b0) begin
        miscompares++;
        $display("FAIL identity_busy pass%0d: busy=%b ready=%b, want 1/0", p, bus0.busy,
                 bus0.ready);
      end
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          vectors++;
          if (get_res(0, i, j) != longint'((p == 1 ? 2 : 1) * (4 * i + j))) begin
            miscompares++;
            $display("FAIL identity_res pass%0d (%0d,%0d): got %0d, want %0d", p, i, j,
                     get_res(0, i, j), (p == 1 ? 2 : 1) * (4 * i + j));
          end
        end
      vectors++;
      if (bus0.ovf !== 1'b0) begin
        miscompares++;
        $display("FAIL identity_ovf pass%0d: got %b, want 0", p, bus0.ovf);
      end
      @(posedge clk); #1;
      vectors++;
      if (bus0.ready !== 1'b1 || bus0.done !== 1'b0) begin
        miscompares++;
        $display("FAIL identity_idle pass%0d: ready=%b done=%b, want 1/0", p, bus0.ready,
                 bus0.done);
      end
    end
  endtask

  task automatic test_max_operands();
    int lat;
    longint want16;
    want16 = Sat ? 65535 : 63492;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        op_a[i][j] = 255;
        op_b[i][j] = 255;
      end
    for (int d = 0; d < 2; d++) begin
      run_pass(d, 1'b1, lat);
      vectors++;
      if (lat != N) begin
        miscompares++;
        $display("FAIL max_latency dut%0d: got %0d, want %0d", d, lat, N);
      end
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          vectors++;
          if (get_res(d, i, j) != (d == 0 ? 64'd260100 : want16)) begin
            miscompares++;
            $display("FAIL max_res dut%0d (%0d,%0d): got %0d, want %0d", d, i, j,
                     get_res(d, i, j), d == 0 ? 64'd260100 : want16);
          end
        end
      vectors++;
      if (get_ovf(d) !== (d == 1)) begin
        miscompares++;
        $display("FAIL max_ovf dut%0d: got %b, want %b", d, get_ovf(d), d == 1);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_clear_idle();
    drive(1, 1'b0, 1'b1, rand_vec(), rand_vec());
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, rand_vec(), rand_vec());
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) m_acc[1][i][j] = 0;
    m_ovf[1] = 1'b0;
    vectors++;
    if (bus1.res !== '0 || bus1.ovf !== 1'b0 || bus1.done !== 1'b0 || bus1.ready !== 1'b1) begin
      miscompares++;
      $display("FAIL clear_idle: res(0,0)=%0d ovf=%b done=%b ready=%b, want 0/0/0/1",
               get_res(1, 0, 0), bus1.ovf, bus1.done, bus1.ready);
    end
  endtask

  task automatic test_random();
    int lat;
    for (int p = 0; p < 8; p++) begin
      int d;
      bit clr;
      d = p % 2;
      clr = 1'($urandom);
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          op_a[i][j] = $urandom_range(255);
          op_b[i][j] = $urandom_range(255);
        end
      run_pass(d, clr, lat);
      vectors++;
      if (lat != N) begin
        miscompares++;
        $display("FAIL random_latency pass%0d: got %0d, want %0d", p, lat, N);
      end
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          vectors++;
          if (get_res(d, i, j) != m_acc[d][i][j]) begin
            miscompares++;
            $display("FAIL random_res pass%0d dut%0d (%0d,%0d): got %0d, want %0d", p, d, i, j,
                     get_res(d, i, j), m_acc[d][i][j]);
          end
        end
      vectors++;
      if (get_ovf(d) !== m_ovf[d]) begin
        miscompares++;
        $display("FAIL random_ovf pass%0d dut%0d: got %b, want %b", p, d, get_ovf(d),
                 m_ovf[d]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        op_a[i][j] = $urandom_range(1, 255);
        op_b[i][j] = $urandom_range(1, 255);
      end
    drive(0, 1'b1, 1'b0, pack(1'b0), pack(1'b1));
    @(posedge clk); #1;
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, pack(1'b0), pack(1'b1));
    rst = 1'b1;
    #1;
    model_reset();
    vectors++;
    if (bus0.res !== '0 || bus0.busy !== 1'b0 || bus0.done !== 1'b0 || bus0.ready !== 1'b1 ||
        bus0.ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: res(0,0)=%0d busy=%b done=%b ready=%b ovf=%b, want 0/0/0/1/0",
               get_res(0, 0, 0), bus0.busy, bus0.done, bus0.ready, bus0.ovf);
    end
    #1 rst = 1'b0;
    // First start after release must be taken on the very next edge.
    run_pass(0, 1'b0, lat);
    vectors++;
    if (lat != N) begin
      miscompares++;
      $display("FAIL reset_restart_latency: got %0d, want %0d", lat, N);
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        vectors++;
        if (get_res(0, i, j) != m_acc[0][i][j]) begin
          miscompares++;
          $display("FAIL reset_restart_res (%0d,%0d): got %0d, want %0d", i, j,
                   get_res(0, i, j), m_acc[0][i][j]);
        end
      end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_identity();
    test_max_operands();
    test_clear_idle();
    test_random();
    test_clear_idle();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
